wm_panel: RTL
=============

WM_PANEL -- requirements
Module: wm_panel

Interface
REQ-001 Parameter DEBOUNCE, default 4: consecutive stable synchronized cycles before a button level is accepted (range 1..15).
REQ-002 Parameter ACK_TIMEOUT, default 8: cycles allowed for the controller to show activity after a start pulse (range 1..15).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 btn_start  input  1  raw asynchronous start button, active-high.
REQ-006 btn_stop  input  1  raw asynchronous stop button, active-high.
REQ-007 ws, rs, ss  input  2 each  controller wash/rinse/spin phase codes: 00 inactive, 01 running, 10 draining, 11 complete.
REQ-008 delay_counter  input  4  controller phase timer; observed only, never drives decisions.
REQ-009 start  output  1  one-cycle start command pulse to the controller.
REQ-010 stop  output  1  one-cycle stop command pulse to the controller.
REQ-011 busy  output  1  high in ARM, RUN and STOPPING.
REQ-012 done_led  output  1  high in DONE.
REQ-013 err  output  1  sticky start-not-acknowledged flag.
REQ-014 cycles_done  output  8  completed-program count, saturating at 255.

Function
REQ-015 Each button: 2-flop synchronizer, then debounce; the debounced level changes only after DEBOUNCE consecutive cycles of the synchronized value differing from it.
REQ-016 Command events are rising edges of the debounced levels; with btn held stable, the event occurs DEBOUNCE+3 rising edges after btn rises.
REQ-017 start and stop are registered and asserted in the cycle after the event; never high together; never high two consecutive cycles.
REQ-018 "active" = any of ws, rs, ss non-zero; "complete" = ss==11.
REQ-019 FSM states: IDLE, ARM, RUN, STOPPING, DONE.
REQ-020 IDLE: start event -> pulse start, clear ACK timer, go ARM; stop event ignored.
REQ-021 ARM: active -> RUN; stop event -> pulse stop, go STOPPING; ACK timer reaches ACK_TIMEOUT while not active -> set err, go IDLE.
REQ-022 RUN: stop event -> pulse stop, go STOPPING; complete -> go DONE, increment cycles_done (held at 255); start events ignored.
REQ-023 RUN with stop event and complete in the same cycle: stop wins, no increment.
REQ-024 STOPPING: not active -> IDLE; start events ignored.
REQ-025 DONE: start event -> pulse start, go ARM; stop event -> go IDLE with no pulse.
REQ-026 Start and stop events in the same cycle: stop rule of current state applies, start discarded.
REQ-027 err clears only on reset or on the next start pulse.

Reset
REQ-028 rst asserted: FSM=IDLE, start=stop=busy=done_led=err=0, cycles_done=0, synchronizers, debounced levels and counters=0, immediately and independent of clk.
REQ-029 Button held across reset deassertion produces an event only after DEBOUNCE+3 edges as per REQ-016; reset mid-program returns to IDLE with no stop pulse.

Structure
REQ-030 Shared package wm_pkg holds FSM state encoding and phase-code constants (PH_IDLE, PH_RUN, PH_DRAIN, PH_DONE), reused by the controller.
REQ-031 One sub-module wm_debounce (synchronizer + debounce + rising-edge detect, parameter DEBOUNCE), instantiated twice.

Verification
REQ-032 Reset, btn_start high 10 cycles, controller drives ws=01 two cycles after start -> one start pulse at edge 7 after press, busy=1, state RUN.
REQ-033 RUN, ss=11 for one cycle -> done_led=1 next cycle, cycles_done 0->1; further ss=11 does not re-increment.
REQ-034 After start pulse, all phases stay 00 for 8 cycles -> err=1, busy=0, IDLE; next start press clears err.
REQ-035 btn_start bouncing (1 cycle high, 1 low, x6) then stable -> exactly one start pulse; 3-cycle glitch on btn_stop -> no stop pulse.
REQ-036 RUN, stop event and ss=11 same cycle -> stop pulse, STOPPING, cycles_done unchanged; phases to 00 -> IDLE.
REQ-037 Preload 255 completions -> cycles_done stays 255; rst asserted mid-RUN -> all outputs 0 without a clk edge.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared constants for the washing-machine front panel and its controller:
// FSM state encoding, controller phase codes and button slot indices.
package wm_pkg;

  // Panel FSM state encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ARM      = 3'd1;
  localparam logic [2:0] ST_RUN      = 3'd2;
  localparam logic [2:0] ST_STOPPING = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  // Controller phase codes (ws/rs/ss)
  localparam logic [1:0] PH_IDLE  = 2'b00;
  localparam logic [1:0] PH_RUN   = 2'b01;
  localparam logic [1:0] PH_DRAIN = 2'b10;
  localparam logic [1:0] PH_DONE  = 2'b11;

  // Button slots in the debouncer array
  localparam int NUM_BTN   = 2;
  localparam int BTN_START = 0;
  localparam int BTN_STOP  = 1;

  // Controller shows activity when any phase leaves PH_IDLE
  function automatic logic phase_active(input logic [1:0] ws, input logic [1:0] rs,
                                        input logic [1:0] ss);
    return (ws != PH_IDLE) || (rs != PH_IDLE) || (ss != PH_IDLE);
  endfunction

  // Saturating 8-bit increment for the completion counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wm_debounce.sv
// One button: 2-flop synchronizer, debounce filter, rising-edge detect.
// The debounced level flips only after DEBOUNCE consecutive synchronized
// samples disagree with it; any agreeing sample restarts the count.
module wm_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic       s1, s2;
  logic       level, level_d;
  logic [3:0] cnt;

  // Two-stage synchronizer for the raw asynchronous button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Count consecutive disagreeing samples; accept the new level on the last one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (s2 != level) begin
      if (cnt == 4'(DEBOUNCE - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // Delayed level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_d <= 1'b0;
    else     level_d <= level;
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/wm_panel.sv
// Front-panel sequencer: debounces start/stop buttons, issues one-cycle
// start/stop commands to the controller and tracks program progress.
module wm_panel import wm_pkg::*; #(
  parameter int DEBOUNCE    = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic [1:0] ws,
  input  logic [1:0] rs,
  input  logic [1:0] ss,
  input  logic [3:0] delay_counter,
  output logic       start,
  output logic       stop,
  output logic       busy,
  output logic       done_led,
  output logic       err,
  output logic [7:0] cycles_done
);

  logic [NUM_BTN-1:0] raw, rise;
  logic [2:0]         state;
  logic [3:0]         ack_cnt;
  logic               ev_start, ev_stop, active, complete;
  logic               unused_delay;

  assign raw = {btn_stop, btn_start};

  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      wm_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
        .clk  (clk),
        .rst  (rst),
        .btn  (raw[i]),
        .rise (rise[i])
      );
    end
  endgenerate

  // A simultaneous stop event always suppresses the start event
  assign ev_stop  = rise[BTN_STOP];
  assign ev_start = rise[BTN_START] & ~rise[BTN_STOP];
  assign active   = phase_active(ws, rs, ss);
  assign complete = (ss == PH_DONE);

  // Phase timer is informational only
  assign unused_delay = ^delay_counter;

  // Panel sequencer: state, command pulses, error flag, completion count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      start       <= 1'b0;
      stop        <= 1'b0;
      err         <= 1'b0;
      cycles_done <= '0;
      ack_cnt     <= '0;
    end else begin
      start <= 1'b0;
      stop  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ev_start) begin
            start   <= 1'b1;
            err     <= 1'b0;
            ack_cnt <= '0;
            state   <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (ev_stop) begin
            stop  <= 1'b1;
            state <= ST_STOPPING;
          end else if (active) begin
            state <= ST_RUN;
          end else if (ack_cnt == 4'(ACK_TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            ack_cnt <= ack_cnt + 4'd1;
          end
        end
        ST_RUN: begin
          if (ev_stop) begin
            stop  <= 1'b1;
            state <= ST_STOPPING;
          end else if (complete) begin
            cycles_done <= sat_inc8(cycles_done);
            state       <= ST_DONE;
          end
        end
        ST_STOPPING: begin
          if (!active) state <= ST_IDLE;
        end
        ST_DONE: begin
          if (ev_stop) begin
            state <= ST_IDLE;
          end else if (ev_start) begin
            start   <= 1'b1;
            err     <= 1'b0;
            ack_cnt <= '0;
            state   <= ST_ARM;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state == ST_ARM) || (state == ST_RUN) || (state == ST_STOPPING);
  assign done_led = (state == ST_DONE);

endmodule
